nios2_jtag_debug_sysclk_bridge: RTL and testbench

Parametrised system-clock side of the Nios II JTAG debug bridge. Synchronises the virtual-JTAG update strobes (`vs_udr`, `vs_uir`) into `clk`, captures the scanned shift register and instruction on each data update, and buffers the captures in a small FIFO. The FIFO drains to the OCI debug logic through a ready-gated, one-hot take-action / take-no-action interface. This generation differs from the fixed 38-bit / 2-bit-IR version in three ways: data width and IR width are parameters; back-to-back JTAG updates are queued rather than overwritten; and overflow is reported.

---
 rtl/nios2_jtag_dbg_pkg.sv | 22 ++
 rtl/nios2_jtag_sync_edge.sv | 50 +++++
 rtl/nios2_jtag_debug_sysclk_bridge.sv | 180 ++++++++++++++++++
 tb/tb_nios2_jtag_debug_sysclk_bridge.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_jtag_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_jtag_dbg_pkg
// Purpose  : Shared defaults and helpers for the system-clock side of the
//            Nios II JTAG debug bridge.
// Contents : default widths/depth, FIFO level-width helper
// Revision : 1.0 - initial parametrised release
// ============================================================================
package nios2_jtag_dbg_pkg;

  localparam int unsigned SR_W_DEF    = 38;
  localparam int unsigned IR_W_DEF    = 2;
  localparam int unsigned ACT_BIT_DEF = 35;
  localparam int unsigned DEPTH_DEF   = 4;

  // Level counter has to represent 0..DEPTH inclusive, hence DEPTH+1.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_jtag_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : nios2_jtag_sync_edge
// Purpose  : 2-flop synchroniser for an asynchronous JTAG update strobe,
//            followed by an armed rising-edge detector.
// Ports    : clk      - system clock
//            reset_n  - asynchronous active-low reset
//            i_async  - asynchronous strobe level
//            o_rise   - combinational one-cycle pulse per armed rising edge
// Revision : 1.0 - initial release
// ============================================================================
module nios2_jtag_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_rise
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic       r_armed;
  // Fill marker: r_fill[1] is set once r_sync holds a genuinely sampled
  // input value rather than its reset value. Without it, the reset 0 in
  // r_sync would count as "seen low" and a strobe held high across reset
  // release would be reported as an edge.
  logic [1:0] r_fill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_rise = r_armed & r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/nios2_jtag_debug_sysclk_bridge.sv
`default_nettype none
// ============================================================================
// Module   : nios2_jtag_debug_sysclk_bridge
// Purpose  : System-clock side of the Nios II JTAG debug bridge. Synchronises
//            the update-DR / update-IR strobes, queues each data update
//            {ir_in, sr} in a small FIFO and drains it to the OCI logic as
//            one-hot take-action / take-no-action pulses.
// Ports    : clk, reset_n          - clock, async active-low reset
//            ir_in, sr             - TCK-domain IR and shift register
//            vs_udr, vs_uir        - asynchronous update strobes
//            cmd_ready             - consumer accepts a pop this cycle
//            clr_overflow          - clears the sticky overflow flag
//            jdo                   - sr of the most recently popped entry
//            take_action           - one-hot pop pulse, action bit = 1
//            take_no_action        - one-hot pop pulse, action bit = 0
//            ir_update             - one pulse per update-IR edge
//            fifo_level            - occupied FIFO entries
//            overflow              - sticky, set when a capture is dropped
// Revision : 1.0 - parametrised widths, queued updates, overflow reporting
// ============================================================================
module nios2_jtag_debug_sysclk_bridge
  import nios2_jtag_dbg_pkg::*;
#(
  parameter int unsigned SR_W    = SR_W_DEF,
  parameter int unsigned IR_W    = IR_W_DEF,
  parameter int unsigned ACT_BIT = ACT_BIT_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [SR_W-1:0]              sr,
  input  logic                         vs_udr,
  input  logic                         vs_uir,
  input  logic                         cmd_ready,
  input  logic                         clr_overflow,
  output logic [SR_W-1:0]              jdo,
  output logic [(2**IR_W)-1:0]         take_action,
  output logic [(2**IR_W)-1:0]         take_no_action,
  output logic                         ir_update,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow
);

  localparam int unsigned NUM_CH  = 2**IR_W;
  localparam int unsigned LEVEL_W = level_w(DEPTH);
  localparam int unsigned PTR_W   = $clog2(DEPTH);

  localparam logic [LEVEL_W-1:0] c_level_full = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] c_level_one  = LEVEL_W'(1);
  localparam logic [PTR_W-1:0]   c_ptr_one    = PTR_W'(1);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
  } fifo_entry_t;

  // --------------------------------------------------------------------------
  // Strobe synchronisers
  // --------------------------------------------------------------------------
  logic w_udr_rise;
  logic w_uir_rise;

  nios2_jtag_sync_edge u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (vs_udr),
    .o_rise  (w_udr_rise)
  );

  nios2_jtag_sync_edge u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (vs_uir),
    .o_rise  (w_uir_rise)
  );

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  fifo_entry_t           r_mem [DEPTH];
  fifo_entry_t           w_head;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LEVEL_W-1:0]    r_level;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_drop;
  logic                  w_act;
  logic [NUM_CH-1:0]     w_onehot;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == c_level_full);
  assign w_pop     = ~w_empty & cmd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // the read of the head happens before the write lands, so with equal
  // pointers the popped data is the old entry.
  assign w_push_ok = w_udr_rise & (~w_full | w_pop);
  assign w_drop    = w_udr_rise & w_full & ~w_pop;
  assign w_act     = w_head.sr[ACT_BIT];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
    assign w_onehot[g] = (w_head.ir == IR_W'(g));
  end

  // Storage carries no reset: emptiness is defined by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= '{ir: ir_in, sr: sr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push_ok && !w_pop) begin
        r_level <= r_level + c_level_one;
      end else if (w_pop && !w_push_ok) begin
        r_level <= r_level - c_level_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic [SR_W-1:0]   r_jdo;
  logic [NUM_CH-1:0] r_take_action;
  logic [NUM_CH-1:0] r_take_no_action;
  logic              r_ir_update;
  logic              r_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_ir_update      <= 1'b0;
      r_overflow       <= 1'b0;
    end else begin
      r_ir_update <= w_uir_rise;
      if (w_pop) begin
        r_jdo            <= w_head.sr;
        r_take_action    <= w_act ? w_onehot : '0;
        r_take_no_action <= w_act ? '0 : w_onehot;
      end else begin
        r_take_action    <= '0;
        r_take_no_action <= '0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign jdo            = r_jdo;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign ir_update      = r_ir_update;
  assign fifo_level     = r_level;
  assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_nios2_jtag_debug_sysclk_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_jtag_debug_sysclk_bridge
// Purpose  : Self-checking bench for nios2_jtag_debug_sysclk_bridge; a
//            default build (38/2/35/4) and a wide build (64/3/60/8) are
//            driven with random payloads and compared to a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_jtag_debug_sysclk_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Default build
  logic [1:0]  a_ir;
  logic [37:0] a_sr;
  logic        a_udr, a_uir, a_rdy, a_clr;
  logic [37:0] a_jdo;
  logic [3:0]  a_ta, a_tna;
  logic        a_iru, a_ovf;
  logic [2:0]  a_lvl;

  // Wide build
  logic [2:0]  b_ir;
  logic [63:0] b_sr;
  logic        b_udr, b_uir, b_rdy, b_clr;
  logic [63:0] b_jdo;
  logic [7:0]  b_ta, b_tna;
  logic        b_iru, b_ovf;
  logic [3:0]  b_lvl;

  nios2_jtag_debug_sysclk_bridge dut_a (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir_in          (a_ir),
    .sr             (a_sr),
    .vs_udr         (a_udr),
    .vs_uir         (a_uir),
    .cmd_ready      (a_rdy),
    .clr_overflow   (a_clr),
    .jdo            (a_jdo),
    .take_action    (a_ta),
    .take_no_action (a_tna),
    .ir_update      (a_iru),
    .fifo_level     (a_lvl),
    .overflow       (a_ovf)
  );

  nios2_jtag_debug_sysclk_bridge #(
    .SR_W    (64),
    .IR_W    (3),
    .ACT_BIT (60),
    .DEPTH   (8)
  ) dut_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir_in          (b_ir),
    .sr             (b_sr),
    .vs_udr         (b_udr),
    .vs_uir         (b_uir),
    .cmd_ready      (b_rdy),
    .clr_overflow   (b_clr),
    .jdo            (b_jdo),
    .take_action    (b_ta),
    .take_no_action (b_tna),
    .ir_update      (b_iru),
    .fifo_level     (b_lvl),
    .overflow       (b_ovf)
  );

  // Reference model: one queue of pending captures per build.
  typedef struct {
    int unsigned ir;
    logic [63:0] sr;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  // Raise update-DR and return just after E+2, when the push is visible.
  // Optional late changes land so that they are sampled at the push edge.
  task automatic a_push(input int unsigned ir, input logic [37:0] s,
                        input bit rdy_at_push, input bit clr_at_push);
    a_ir  = 2'(ir);
    a_sr  = s;
    a_udr = 1'b1;
    step();                       // E
    step();                       // E+1
    if (rdy_at_push) a_rdy = 1'b1;
    if (clr_at_push) a_clr = 1'b1;
    step();                       // E+2
  endtask

  task automatic a_release();
    a_udr = 1'b0;
    a_clr = 1'b0;
    repeat (4) step();
  endtask

  task automatic b_push(input int unsigned ir, input logic [63:0] s);
    b_ir  = 3'(ir);
    b_sr  = s;
    b_udr = 1'b1;
    repeat (3) step();
    b_udr = 1'b0;
    repeat (4) step();
  endtask

  task automatic a_check_pop(input string tag);
    ent_t        e;
    logic [63:0] one;
    if (qa.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=pop expected=empty model", tag);
    end else begin
      e   = qa.pop_front();
      one = 64'd1 << e.ir;
      chk({tag, "_jdo"}, 64'(a_jdo), {26'd0, e.sr[37:0]});
      chk({tag, "_ta"},  64'(a_ta),  e.sr[35] ? one : 64'd0);
      chk({tag, "_tna"}, 64'(a_tna), e.sr[35] ? 64'd0 : one);
    end
  endtask

  task automatic a_check_idle(input string tag);
    chk({tag, "_ta"},  64'(a_ta),  64'd0);
    chk({tag, "_tna"}, 64'(a_tna), 64'd0);
  endtask

  function automatic logic [37:0] a_payload(input bit act);
    logic [63:0] v;
    v     = rnd64();
    v[35] = act;
    return v[37:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t        e;
    logic [37:0] s;
    logic [63:0] sb;
    logic [63:0] one;
    int          pulses;

    reset_n = 1'b0;
    a_ir = '0; a_sr = '0; a_udr = 1'b1; a_uir = 1'b0; a_rdy = 1'b0; a_clr = 1'b0;
    b_ir = '0; b_sr = '0; b_udr = 1'b0; b_uir = 1'b0; b_rdy = 1'b0; b_clr = 1'b0;
    repeat (3) step();

    // ---- Reset state
    chk("rst_jdo", 64'(a_jdo), 64'd0);
    chk("rst_ta",  64'(a_ta),  64'd0);
    chk("rst_tna", 64'(a_tna), 64'd0);
    chk("rst_iru", 64'(a_iru), 64'd0);
    chk("rst_lvl", 64'(a_lvl), 64'd0);
    chk("rst_ovf", 64'(a_ovf), 64'd0);
    chk("rst_b_lvl", 64'(b_lvl), 64'd0);
    chk("rst_b_ta",  64'(b_ta),  64'd0);

    // ---- Release reset with update-DR held high: no capture
    reset_n = 1'b1;
    repeat (10) begin
      step();
      chk("held_lvl", 64'(a_lvl), 64'd0);
    end
    a_udr = 1'b0;
    repeat (4) step();
    chk("held_drop_lvl", 64'(a_lvl), 64'd0);
    a_check_idle("held_drop");

    // ---- First real pulse, consumer ready: action pulse at E+3
    a_rdy = 1'b1;
    s = a_payload(1'b1);
    a_push(1, s, 1'b0, 1'b0);
    qa.push_back('{ir: 1, sr: 64'(s)});
    chk("t1_lvl_e2", 64'(a_lvl), 64'd1);
    a_check_idle("t1_e2");
    step();
    chk("t1_ta_const", 64'(a_ta), 64'h2);
    a_check_pop("t1_pop");
    chk("t1_lvl_e3", 64'(a_lvl), 64'd0);
    a_release();
    a_check_idle("t1_after");

    // ---- Queued pops: IR 0..3, action 1,0,1,0
    a_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = a_payload(i % 2 == 0);
      a_push(i, s, 1'b0, 1'b0);
      qa.push_back('{ir: i, sr: 64'(s)});
      a_release();
    end
    chk("t2_lvl_full", 64'(a_lvl), 64'd4);
    a_check_idle("t2_held");
    a_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      a_check_pop($sformatf("t2_pop%0d", i));
    end
    a_rdy = 1'b0;
    step();
    chk("t2_lvl_empty", 64'(a_lvl), 64'd0);
    a_check_idle("t2_after");

    // ---- Overflow, at two different pointer alignments
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        s = a_payload($urandom_range(1));
        a_push($urandom_range(3), s, 1'b0, 1'b0);
        e.ir = a_ir; e.sr = 64'(s);
        qa.push_back(e);
        a_release();
      end
      // Fifth push: dropped, and a same-cycle clear loses to the drop.
      s = a_payload(1'b1);
      a_push(2, s, 1'b0, 1'b1);
      chk($sformatf("t3_%0d_ovf_set", pass), 64'(a_ovf), 64'd1);
      chk($sformatf("t3_%0d_lvl", pass), 64'(a_lvl), 64'd4);
      a_release();
      chk($sformatf("t3_%0d_ovf_sticky", pass), 64'(a_ovf), 64'd1);
      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      chk($sformatf("t3_%0d_ovf_clr", pass), 64'(a_ovf), 64'd0);
      a_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        a_check_pop($sformatf("t3_%0d_pop%0d", pass, i));
      end
      a_rdy = 1'b0;
      step();
      chk($sformatf("t3_%0d_lvl_empty", pass), 64'(a_lvl), 64'd0);
      // Shift pointer alignment for the next pass.
      a_rdy = 1'b1;
      for (int i = 0; i < 2; i++) begin
        s = a_payload(1'b0);
        a_push(i, s, 1'b0, 1'b0);
        qa.push_back('{ir: i, sr: 64'(s)});
        step();
        a_check_pop($sformatf("t3_%0d_shift%0d", pass, i));
        a_release();
      end
      a_rdy = 1'b0;
    end

    // ---- Push and pop on the same edge while full
    for (int i = 0; i < 4; i++) begin
      s = a_payload($urandom_range(1));
      a_push(3 - i, s, 1'b0, 1'b0);
      qa.push_back('{ir: 3 - i, sr: 64'(s)});
      a_release();
    end
    s = a_payload(1'b1);
    a_push(3, s, 1'b1, 1'b0);
    a_check_pop("t4_pop_at_push");
    qa.push_back('{ir: 3, sr: 64'(s)});
    chk("t4_lvl", 64'(a_lvl), 64'd4);
    chk("t4_ovf", 64'(a_ovf), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      a_check_pop($sformatf("t4_pop%0d", i));
    end
    a_release();
    a_rdy = 1'b0;
    chk("t4_lvl_empty", 64'(a_lvl), 64'd0);

    // ---- IR update: single pulse at E+2, FIFO untouched
    a_uir = 1'b1;
    step();                                  // E
    chk("t5_iru_e0", 64'(a_iru), 64'd0);
    step();                                  // E+1
    chk("t5_iru_e1", 64'(a_iru), 64'd0);
    step();                                  // E+2
    chk("t5_iru_e2", 64'(a_iru), 64'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) a_uir = 1'b0;
      pulses += int'(a_iru);
    end
    chk("t5_iru_single", 64'(pulses), 64'd0);
    chk("t5_lvl", 64'(a_lvl), 64'd0);
    a_check_idle("t5");

    // ---- Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      s = a_payload($urandom_range(1));
      a_push(i, s, 1'b0, 1'b0);
      qa.push_back('{ir: i, sr: 64'(s)});
      a_release();
    end
    chk("t6_lvl_pre", 64'(a_lvl), 64'd3);
    reset_n = 1'b0;
    #2;
    chk("t6_jdo", 64'(a_jdo), 64'd0);
    chk("t6_lvl", 64'(a_lvl), 64'd0);
    chk("t6_ovf", 64'(a_ovf), 64'd0);
    chk("t6_iru", 64'(a_iru), 64'd0);
    a_check_idle("t6_rst");
    qa.delete();
    step();
    reset_n = 1'b1;
    a_rdy   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      a_check_idle($sformatf("t6_stale%0d", i));
    end
    chk("t6_lvl_post", 64'(a_lvl), 64'd0);
    a_rdy = 1'b0;

    // ---- Wide build: 8-deep, 8 channels, overflow on ninth push
    repeat (4) step();
    for (int i = 0; i < 9; i++) begin
      sb = rnd64();
      sb[60] = (i == 7) ? 1'b1 : 1'($urandom_range(1));
      b_push(i % 8, sb);
      if (qb.size() < 8) qb.push_back('{ir: i % 8, sr: sb});
      if (i == 7) begin
        chk("t7_lvl_full", 64'(b_lvl), 64'd8);
        chk("t7_ovf_clear", 64'(b_ovf), 64'd0);
      end
    end
    chk("t7_ovf_set", 64'(b_ovf), 64'd1);
    chk("t7_lvl_held", 64'(b_lvl), 64'd8);
    b_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      e   = qb.pop_front();
      one = 64'd1 << e.ir;
      chk($sformatf("t7_pop%0d_jdo", i), b_jdo, e.sr);
      chk($sformatf("t7_pop%0d_ta", i),  64'(b_ta),  e.sr[60] ? one : 64'd0);
      chk($sformatf("t7_pop%0d_tna", i), 64'(b_tna), e.sr[60] ? 64'd0 : one);
    end
    b_rdy = 1'b0;
    step();
    chk("t7_lvl_empty", 64'(b_lvl), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
